// File: rtl/zx_mem_pager.sv
// zx_mem_pager: ZX Spectrum paging unit.
// Decodes the paging ports (7FFD, FE and, optionally, 1FFD) from the
// asynchronous Z80 bus, holds the paging state, and maps the CPU address
// onto physical RAM/ROM addresses. RAM size is 128k, 512k or 1024k.
// Optional feature macro: SPECIAL_PAGING_EN (+3-style 1FFD port with
// all-RAM mode and a second ROM page bit). The default build leaves it out.
module zx_mem_pager #(
  parameter int RAM_KB      = 128,
  parameter int ROM_PAGES   = 2,
  parameter int FULL_DECODE = 0,
  parameter int RAM_AW      = 20
) (
  input  logic              clock_25,
  input  logic              RESET_N,
  input  logic [15:0]       A,
  input  logic [7:0]        D,
  input  logic              nIORQ,
  input  logic              nMREQ,
  input  logic              nWR,
  input  logic              nRD,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       rom_addr,
  output logic              rom_sel,
  output logic              ram_we,
  output logic              vid_bank,
  output logic [2:0]        border,
  output logic              page_lock,
  output logic              port_wr
);

  // Bank register width for the configured RAM size. The bank register is
  // held as 6 bits internally; bits above BANK_W stay zero, which gives the
  // zero extension of ram_addr for free.
  localparam int BANK_W = (RAM_KB == 1024) ? 6 : ((RAM_KB == 512) ? 5 : 3);
  localparam logic [5:0] BANK_MASK = 6'((1 << BANK_W) - 1);

  // Only page bits that exist in the fitted ROM can be driven.
  localparam logic [1:0] ROM_PG_MASK = (ROM_PAGES > 2) ? 2'b11 : 2'b01;

  localparam bit IS_1024 = (RAM_KB == 1024);
  localparam bit IS_BIG  = (RAM_KB >= 512);
  localparam bit IS_FULL = (FULL_DECODE != 0);

  // Bus synchroniser stages (two flops per signal, third nWR flop for edge).
  logic        r_niorq_s1, r_niorq_s2;
  logic        r_nwr_s1, r_nwr_s2, r_nwr_s3;
  logic [15:0] r_a_s1, r_a_s2;
  logic [7:0]  r_d_s1, r_d_s2;

  // Paging state.
  logic [5:0]  r_bank;
  logic        r_vid_bank;
  logic        r_rom_pg0;
  logic        r_page_lock;
  logic [2:0]  r_border;
  logic        r_port_wr;

  // Decode and map wires.
  logic        w_wr_det;
  logic        w_hit_7ffd;
  logic        w_hit_fe;
  logic        w_accept_7ffd;
  logic [5:0]  w_bank_next;
  logic        w_lock_next;
  logic        w_rom_sel;
  logic [5:0]  w_slot_bank;
  logic        w_rom_hi;
  logic [1:0]  w_rom_page;
  logic        w_unused;

  // nRD is part of the bus interface but paging never depends on reads.
  assign w_unused = nRD;

  // Bring the asynchronous CPU bus into the clock_25 domain.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the stages.
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      r_niorq_s1 <= 1'b0;
      r_niorq_s2 <= 1'b0;
      r_nwr_s1   <= 1'b0;
      r_nwr_s2   <= 1'b0;
      r_nwr_s3   <= 1'b0;
      r_a_s1     <= '0;
      r_a_s2     <= '0;
      r_d_s1     <= '0;
      r_d_s2     <= '0;
    end else begin
      r_niorq_s1 <= nIORQ;
      r_niorq_s2 <= r_niorq_s1;
      r_nwr_s1   <= nWR;
      r_nwr_s2   <= r_nwr_s1;
      r_nwr_s3   <= r_nwr_s2;
      r_a_s1     <= A;
      r_a_s2     <= r_a_s1;
      r_d_s1     <= D;
      r_d_s2     <= r_d_s1;
    end
  end

  // An I/O write is a falling edge of synced nWR while synced nIORQ is low.
  // A held-low nWR shows no further edge, so it cannot retrigger.
  assign w_wr_det   = r_nwr_s3 & ~r_nwr_s2 & ~r_niorq_s2;

  assign w_hit_7ffd = IS_FULL ? (r_a_s2 == 16'h7FFD)
                              : (~r_a_s2[15] & ~r_a_s2[1]);
  assign w_hit_fe   = ~r_a_s2[0];

  assign w_accept_7ffd = w_wr_det & w_hit_7ffd & ~r_page_lock;

  // 1024k reuses D[5] as the top bank bit, so the lock is unavailable there.
  assign w_bank_next = {r_d_s2[5] & IS_1024, r_d_s2[7:6] & {2{IS_BIG}},
                        r_d_s2[2:0]} & BANK_MASK;
  assign w_lock_next = IS_1024 ? 1'b0 : r_d_s2[5];

  // Paging, border and port-write pulse registers; reset beats any write.
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      r_bank      <= '0;
      r_vid_bank  <= 1'b0;
      r_rom_pg0   <= 1'b0;
      r_page_lock <= 1'b0;
      r_border    <= '0;
      r_port_wr   <= 1'b0;
    end else begin
      r_port_wr <= w_wr_det;
      if (w_accept_7ffd) begin
        r_bank      <= w_bank_next;
        r_vid_bank  <= r_d_s2[3];
        r_rom_pg0   <= r_d_s2[4];
        r_page_lock <= w_lock_next;
      end
      if (w_wr_det && w_hit_fe) begin
        r_border <= r_d_s2[2:0];
      end
    end
  end

`ifdef SPECIAL_PAGING_EN
  logic [2:0] r_spec;
  logic       w_hit_1ffd;

  assign w_hit_1ffd = IS_FULL ? (r_a_s2 == 16'h1FFD)
                              : ((r_a_s2[15:12] == 4'b0001) & ~r_a_s2[1]);

  // 1FFD register: all-RAM enable, bank-set select / ROM high page bit.
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      r_spec <= '0;
    end else if (w_wr_det && w_hit_1ffd && !r_page_lock) begin
      r_spec <= r_d_s2[2:0];
    end
  end

  // Bank for a slot in all-RAM mode, from the selected bank set.
  function automatic logic [5:0] special_bank(input logic [1:0] set,
                                              input logic [1:0] slot);
    case (set)
      2'b00:   return {4'd0, slot};
      2'b01:   return {4'd1, slot};
      2'b10:   return (slot == 2'd3) ? 6'd3 : {4'd1, slot};
      default: begin
        case (slot)
          2'd0:    return 6'd4;
          2'd1:    return 6'd7;
          2'd2:    return 6'd6;
          default: return 6'd3;
        endcase
      end
    endcase
  endfunction

  assign w_rom_hi = r_spec[2];
`else
  assign w_rom_hi = 1'b0;
`endif

  // Slot decode: ROM or fixed/paged RAM bank for the current CPU address.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_rom_sel   = 1'b0;
    w_slot_bank = 6'd0;
    case (A[15:14])
      2'b00:   w_rom_sel   = 1'b1;
      2'b01:   w_slot_bank = 6'd5;
      2'b10:   w_slot_bank = 6'd2;
      default: w_slot_bank = r_bank;
    endcase
`ifdef SPECIAL_PAGING_EN
    if (r_spec[0]) begin
      w_rom_sel   = 1'b0;
      w_slot_bank = special_bank(r_spec[2:1], A[15:14]);
    end
`endif
  end

  // A set lock forces the 48k ROM regardless of rom_pg0.
  assign w_rom_page = {w_rom_hi, r_rom_pg0 | r_page_lock} & ROM_PG_MASK;

  assign ram_addr  = RAM_AW'({w_slot_bank, A[13:0]});
  assign rom_addr  = {w_rom_page, A[13:0]};
  assign rom_sel   = w_rom_sel;
  // Raw bus strobes on purpose: the memory clock qualifies this enable.
  assign ram_we    = ~nMREQ & ~nWR & ~w_rom_sel;
  assign vid_bank  = r_vid_bank;
  assign border    = r_border;
  assign page_lock = r_page_lock;
  assign port_wr   = r_port_wr;

endmodule

// File: tb/tb_zx_mem_pager.sv
// tb_zx_mem_pager: three pager instances (128k partial decode, 512k partial
// decode, 1024k full decode) on one shared bus, checked every cycle against
// a behavioural paging model, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_zx_mem_pager;

`ifdef SPECIAL_PAGING_EN
  localparam bit SPECIAL = 1'b1;
  localparam int ROM_P   = 4;
`else
  localparam bit SPECIAL = 1'b0;
  localparam int ROM_P   = 2;
`endif

  logic        clock_25 = 1'b0;
  logic        RESET_N;
  logic [15:0] A;
  logic [7:0]  D;
  logic        nIORQ, nMREQ, nWR, nRD;

  logic [19:0] ra0, ra1, ra2;
  logic [15:0] ro0, ro1, ro2;
  logic        rs0, rs1, rs2, we0, we1, we2, vb0, vb1, vb2;
  logic        pl0, pl1, pl2, pw0, pw1, pw2;
  logic [2:0]  bd0, bd1, bd2;

  always #20 clock_25 = ~clock_25;

  zx_mem_pager #(.RAM_KB(128), .ROM_PAGES(ROM_P), .FULL_DECODE(0), .RAM_AW(20)) u128 (
    .clock_25(clock_25), .RESET_N(RESET_N), .A(A), .D(D), .nIORQ(nIORQ),
    .nMREQ(nMREQ), .nWR(nWR), .nRD(nRD), .ram_addr(ra0), .rom_addr(ro0),
    .rom_sel(rs0), .ram_we(we0), .vid_bank(vb0), .border(bd0),
    .page_lock(pl0), .port_wr(pw0));

  zx_mem_pager #(.RAM_KB(512), .ROM_PAGES(ROM_P), .FULL_DECODE(0), .RAM_AW(20)) u512 (
    .clock_25(clock_25), .RESET_N(RESET_N), .A(A), .D(D), .nIORQ(nIORQ),
    .nMREQ(nMREQ), .nWR(nWR), .nRD(nRD), .ram_addr(ra1), .rom_addr(ro1),
    .rom_sel(rs1), .ram_we(we1), .vid_bank(vb1), .border(bd1),
    .page_lock(pl1), .port_wr(pw1));

  zx_mem_pager #(.RAM_KB(1024), .ROM_PAGES(ROM_P), .FULL_DECODE(1), .RAM_AW(20)) u1k (
    .clock_25(clock_25), .RESET_N(RESET_N), .A(A), .D(D), .nIORQ(nIORQ),
    .nMREQ(nMREQ), .nWR(nWR), .nRD(nRD), .ram_addr(ra2), .rom_addr(ro2),
    .rom_sel(rs2), .ram_we(we2), .vid_bank(vb2), .border(bd2),
    .page_lock(pl2), .port_wr(pw2));

  // ---------------------------------------------------------------- model
  int kb[3]   = '{128, 512, 1024};
  bit full[3] = '{1'b0, 1'b0, 1'b1};
  int sets[4][4] = '{'{0, 1, 2, 3}, '{4, 5, 6, 7}, '{4, 5, 6, 3}, '{4, 7, 6, 3}};
  int m_bank[3], m_vid[3], m_rpg[3], m_lock[3], m_border[3], m_spec[3];
  bit m_pw;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  int pw_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_bank[k] = 0; m_vid[k] = 0; m_rpg[k] = 0;
      m_lock[k] = 0; m_border[k] = 0; m_spec[k] = 0;
    end
    m_pw = 1'b0;
  endfunction

  // Effect of one I/O write on every instance's architectural state.
  function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
    for (int k = 0; k < 3; k++) begin
      bit h7, h1;
      int was_locked;
      h7 = full[k] ? (a == 16'h7FFD) : (a[15] == 1'b0 && a[1] == 1'b0);
      h1 = SPECIAL && (full[k] ? (a == 16'h1FFD)
                               : (a[15:12] == 4'h1 && a[1] == 1'b0));
      was_locked = m_lock[k];
      if (h7 && was_locked == 0) begin
        m_bank[k] = int'(d[2:0]);
        if (kb[k] >= 512)  m_bank[k] += int'(d[7:6]) * 8;
        if (kb[k] == 1024) m_bank[k] += int'(d[5]) * 32;
        m_vid[k]  = int'(d[3]);
        m_rpg[k]  = int'(d[4]);
        m_lock[k] = (kb[k] == 1024) ? 0 : int'(d[5]);
      end
      if (a[0] == 1'b0) m_border[k] = int'(d[2:0]);
      if (h1 && was_locked == 0) m_spec[k] = int'(d[2:0]);
    end
  endfunction

  task automatic cmp_inst(input int k, input logic [19:0] ra, input logic [15:0] ro,
                          input logic rs, input logic we, input logic vb,
                          input logic [2:0] bd, input logic pl, input logic pw);
    int slot, off, e_bank, e_pg, e_ram, e_rom;
    bit e_rs;
    slot   = int'(A[15:14]);
    off    = int'(A[13:0]);
    e_rs   = 1'b0;
    e_bank = 0;
    if (SPECIAL && (m_spec[k] & 1) == 1) begin
      e_bank = sets[(m_spec[k] >> 1) & 3][slot];
    end else if (slot == 0) begin
      e_rs = 1'b1;
    end else begin
      e_bank = (slot == 1) ? 5 : ((slot == 2) ? 2 : m_bank[k]);
    end
    e_pg  = (m_rpg[k] | m_lock[k]) + (SPECIAL ? ((m_spec[k] >> 2) & 1) * 2 : 0);
    e_ram = e_bank * 16384 + off;
    e_rom = e_pg * 16384 + off;
    check($sformatf("i%0d.rom_sel A=%h", k, A), 32'(rs), 32'(e_rs));
    if (e_rs) check($sformatf("i%0d.rom_addr A=%h", k, A), 32'(ro), e_rom);
    else      check($sformatf("i%0d.ram_addr A=%h", k, A), 32'(ra), e_ram);
    check($sformatf("i%0d.ram_we", k), 32'(we), 32'(!nMREQ && !nWR && !e_rs));
    check($sformatf("i%0d.vid_bank", k), 32'(vb), m_vid[k]);
    check($sformatf("i%0d.border", k), 32'(bd), m_border[k]);
    check($sformatf("i%0d.page_lock", k), 32'(pl), m_lock[k]);
    check($sformatf("i%0d.port_wr", k), 32'(pw), 32'(m_pw));
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock_25) begin
    if (chk_en) begin
      cmp_inst(0, ra0, ro0, rs0, we0, vb0, bd0, pl0, pw0);
      cmp_inst(1, ra1, ro1, rs1, we1, vb1, bd1, pl1, pw1);
      cmp_inst(2, ra2, ro2, rs2, we2, vb2, bd2, pl2, pw2);
      if (pw0) pw_cnt++;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic do_reset(input int n);
    @(posedge clock_25); #5;
    RESET_N = 1'b0;
    repeat (n) begin
      @(posedge clock_25);
      model_reset();
    end
    #5 RESET_N = 1'b1;
  endtask

  // OUT (addr),data with nWR held low for about 'hold' clocks. The write
  // lands on the third clock edge after nWR falls.
  task automatic out_port(input logic [15:0] addr, input logic [7:0] data, input int hold);
    @(posedge clock_25); #5;
    A = addr; D = data; nMREQ = 1'b1; nIORQ = 1'b0; nWR = 1'b0;
    repeat (3) @(posedge clock_25);
    model_write(addr, data);
    m_pw = 1'b1;
    @(posedge clock_25);
    m_pw = 1'b0;
    if (hold > 4) repeat (hold - 4) @(posedge clock_25);
    #5 nWR = 1'b1; nIORQ = 1'b1;
    repeat (4) @(posedge clock_25);
  endtask

  // Drive an address and stop on the following falling edge for checks.
  task automatic probe(input logic [15:0] addr);
    @(posedge clock_25); #5;
    A = addr;
    @(negedge clock_25);
  endtask

  task automatic mem_wr(input logic [15:0] addr);
    @(posedge clock_25); #5;
    A = addr; nMREQ = 1'b0; nWR = 1'b0;
    @(negedge clock_25);
  endtask

  task automatic bus_idle();
    @(posedge clock_25); #5;
    nMREQ = 1'b1; nWR = 1'b1; nIORQ = 1'b1;
    repeat (4) @(posedge clock_25);
  endtask

  // I/O write cut by reset on the edge where it would be detected.
  task automatic reset_mid_write();
    @(posedge clock_25); #5;
    A = 16'h7FFD; D = 8'h3F; nIORQ = 1'b0; nWR = 1'b0;
    repeat (2) @(posedge clock_25);
    #5 RESET_N = 1'b0;
    @(posedge clock_25);
    model_reset();
    #5 RESET_N = 1'b1;
    repeat (5) @(posedge clock_25);
    #5 nWR = 1'b1; nIORQ = 1'b1;
    repeat (4) @(posedge clock_25);
  endtask

  initial begin
    A = 16'h0000; D = 8'h00; nIORQ = 1'b1; nMREQ = 1'b1; nWR = 1'b1; nRD = 1'b1;
    RESET_N = 1'b0;
    model_reset();

    // 1: reset state
    repeat (2) @(posedge clock_25);
    model_reset();
    chk_en = 1'b1;
    #5 RESET_N = 1'b1;
    probe(16'hC123);
    check("t1.rom_sel", 32'(rs0), 32'h0);
    check("t1.ram_addr", 32'(ra0), 32'h00123);
    check("t1.border", 32'(bd0), 32'h0);
    check("t1.page_lock", 32'(pl0), 32'h0);
    check("t1.vid_bank", 32'(vb0), 32'h0);

    // 2: 7FFD = 0x1B -> bank 3, screen 7, ROM page 1
    out_port(16'h7FFD, 8'h1B, 6);
    check("t2.pw_count", 32'(pw_cnt), 32'd1);
    probe(16'hC000);
    check("t2.ram_addr", 32'(ra0), 32'h0C000);
    check("t2.vid_bank", 32'(vb0), 32'h1);
    probe(16'h0010);
    check("t2.rom_addr", 32'(ro0), 32'h4010);

    // 3: lock, then a write that must be ignored (1024k has no lock)
    out_port(16'h7FFD, 8'h20, 6);
    out_port(16'h7FFD, 8'h07, 6);
    check("t3.pw_count", 32'(pw_cnt), 32'd3);
    probe(16'hC000);
    check("t3.ram_addr", 32'(ra0), 32'h00000);
    check("t3.page_lock", 32'(pl0), 32'h1);
    check("t3.ram_addr_1k", 32'(ra2), 32'h1C000);
    check("t3.lock_1k", 32'(pl2), 32'h0);
    probe(16'h0000);
    check("t3.rom_addr", 32'(ro0), 32'h4000);

    // 4: extended banks, nWR held low 20 clocks -> single pulse
    do_reset(2);
    out_port(16'h7FFD, 8'hC7, 20);
    check("t4.pw_count", 32'(pw_cnt), 32'd4);
    probe(16'hFFFF);
    check("t4.ram_addr_512", 32'(ra1), 32'h7FFFF);
    check("t4.ram_addr_128", 32'(ra0), 32'h1FFFF);
    check("t4.ram_addr_1k", 32'(ra2), 32'h7FFFF);

    // 5: border port, then memory writes to ROM and RAM space
    out_port(16'h00FE, 8'h05, 6);
    probe(16'hFFFF);
    check("t5.border", 32'(bd0), 32'h5);
    check("t5.ram_addr", 32'(ra0), 32'h1FFFF);
    mem_wr(16'h1000);
    check("t5.ram_we_rom", 32'(we0), 32'h0);
    mem_wr(16'hC000);
    check("t5.ram_we_ram", 32'(we0), 32'h1);
    bus_idle();
    // one write decoded as both 7FFD (partial) and FE
    out_port(16'h3FFC, 8'h12, 6);
    probe(16'hC000);
    check("t5.both_border", 32'(bd0), 32'h2);
    check("t5.both_ram", 32'(ra0), 32'h08000);
    check("t5.both_ram_1k", 32'(ra2), 32'h7C000);

    // 6: reset lands on the detect edge -> all clear, no pulse
    reset_mid_write();
    check("t6.pw_count", 32'(pw_cnt), 32'd6);
    probe(16'hC000);
    check("t6.ram_addr", 32'(ra0), 32'h00000);
    check("t6.border", 32'(bd0), 32'h0);
    check("t6.page_lock", 32'(pl0), 32'h0);
    out_port(16'h7FFD, 8'h11, 6);
    check("t6.pw_after", 32'(pw_cnt), 32'd7);
    probe(16'hC000);
    check("t6.ram_after", 32'(ra0), 32'h04000);

`ifdef SPECIAL_PAGING_EN
    // 7: all-RAM, set {4,5,6,3}; then normal mode with ROM page bit 1
    out_port(16'h1FFD, 8'h05, 6);
    probe(16'h0000);
    check("t7.rom_sel", 32'(rs0), 32'h0);
    check("t7.slot0", 32'(ra0), 32'h10000);
    check("t7.slot0_1k", 32'(ra2), 32'h10000);
    probe(16'hC000);
    check("t7.slot3", 32'(ra0), 32'h0C000);
    out_port(16'h1FFD, 8'h04, 6);
    probe(16'h0010);
    check("t7.rom_sel_n", 32'(rs0), 32'h1);
    check("t7.rom_addr", 32'(ro0), 32'h8010);
`endif

    @(posedge clock_25);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
